dfa_ctx_sched: RTL

DFA_CTX_SCHED -- requirements
Module: dfa_ctx_sched

---
 rtl/dfa_ctx_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dfa_ctx_sched.sv
// dfa_ctx_sched: time-multiplexes one DFA engine across NREQ character streams.
// Each stream keeps its DFA state in a context table. The state is loaded into the
// engine when the stream is granted and saved back when the grant ends.
// Optional feature: define DFA_SCHED_MATCH_CNT_EN to add per-requester saturating
// match counters that are read through cnt_sel/cnt_out.
module dfa_ctx_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [8*NREQ-1:0]   req_char,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_rdy,
  output logic [7:0]          eng_char,
  output logic                eng_char_vld,
  output logic [10:0]         eng_state_in,
  output logic                eng_state_in_vld,
  input  logic [10:0]         eng_state_out,
  input  logic                eng_accept,
  output logic                match_vld,
  output logic [1:0]          match_id,
  output logic                busy
`ifdef DFA_SCHED_MATCH_CNT_EN
  ,
  input  logic [1:0]          cnt_sel,
  output logic [15:0]         cnt_out
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} state_t;

  state_t      state_q;
  logic [1:0]  grant_q;
  logic [1:0]  rr_q;
  logic [7:0]  bcnt_q;
  logic        last_q;
  logic [10:0] ctx_q [NREQ];
  logic [10:0] st_in_q;
  logic        st_in_vld_q;
  logic        match_vld_q;
  logic [1:0]  match_id_q;

  logic        pick_vld;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        in_run;
  logic        lane_vld;
  logic        lane_last;
  logic [7:0]  lane_char;
  logic        burst_hit;

  // Round-robin search starting at the requester after the previous grant
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_q;
    cand     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!pick_vld && req_vld[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Granted-lane steering; the handshake is combinational during RUN only
  always_comb begin
    in_run       = (state_q == RUN);
    lane_vld     = req_vld[grant_q];
    lane_last    = req_last[grant_q];
    lane_char    = req_char[{grant_q, 3'b000} +: 8];
    burst_hit    = (({1'b0, bcnt_q} + 9'd1) == 9'(BURST));
    req_rdy      = in_run ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    eng_char     = in_run ? lane_char : '0;
    eng_char_vld = in_run & lane_vld;
  end

  assign eng_state_in     = st_in_q;
  assign eng_state_in_vld = st_in_vld_q;
  assign busy             = (state_q != IDLE);
  assign match_vld        = match_vld_q;
  assign match_id         = match_id_q;

  // Scheduler FSM: grant, load context, stream a burst, save context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      bcnt_q      <= '0;
      last_q      <= 1'b0;
      st_in_q     <= '0;
      st_in_vld_q <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) ctx_q[i] <= '0;
    end else begin
      st_in_q     <= '0;
      st_in_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q     <= pick;
            rr_q        <= pick + 2'd1;
            st_in_q     <= ctx_q[pick];
            st_in_vld_q <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          bcnt_q  <= '0;
          last_q  <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          if (lane_vld) begin
            bcnt_q <= bcnt_q + 8'd1;
            if (lane_last || burst_hit) begin
              last_q  <= lane_last;
              state_q <= SAVE;
            end
          end else begin
            state_q <= SAVE;
          end
        end
        SAVE: begin
          // A finished packet restarts from state 0; otherwise resume where the engine stopped
          ctx_q[grant_q] <= last_q ? '0 : eng_state_out;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-cycle registered match pulse tagged with the granted requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_vld_q <= 1'b0;
      match_id_q  <= '0;
    end else begin
      match_vld_q <= eng_char_vld & eng_accept;
      if (eng_char_vld & eng_accept) match_id_q <= grant_q;
    end
  end

`ifdef DFA_SCHED_MATCH_CNT_EN
  logic [15:0] mcnt_q [NREQ];
  logic [15:0] cnt_out_q;

  assign cnt_out = cnt_out_q;

  // Saturating per-requester match counters with a registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) mcnt_q[i] <= '0;
      cnt_out_q <= '0;
    end else begin
      if (match_vld_q && (mcnt_q[match_id_q] != '1))
        mcnt_q[match_id_q] <= mcnt_q[match_id_q] + 16'd1;
      cnt_out_q <= mcnt_q[cnt_sel];
    end
  end
`endif

endmodule
